// File: rtl/control_unit_if.sv
// control_unit_if: instruction/accumulator inputs and datapath control strobes of the sequencer.
interface control_unit_if;
  logic [15:0] ir;
  logic [15:0] acc;
  logic [2:0]  bus_sel;
  logic        mar_write;
  logic        mbr_write;
  logic        ir_write;
  logic        pc_write;
  logic        acc_write;
  logic        pc_inc;
  logic        acc_src;
  logic        acc_clr;
  logic [3:0]  alu_op;
  logic        mem_we;
  modport master (
    input  ir, acc,
    output bus_sel, mar_write, mbr_write, ir_write, pc_write, acc_write,
           pc_inc, acc_src, acc_clr, alu_op, mem_we
  );
  modport slave (
    output ir, acc,
    input  bus_sel, mar_write, mbr_write, ir_write, pc_write, acc_write,
           pc_inc, acc_src, acc_clr, alu_op, mem_we
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer with registered Moore strobes.
// Define SKIPCOND_EN to enable opcode 8 (SKIPCOND); otherwise opcode 8 decodes as NOP.
module control_unit (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  control_unit_if.master bus,
  output logic           halted,
  output logic [15:0]    instr_count
);
  typedef enum logic [3:0] {IDLE, F0, F1, F2, DEC, EX0, EX1, EX2, HALT} state_t;
  typedef struct packed {
    logic [2:0] bus_sel;
    logic       mar_write;
    logic       mbr_write;
    logic       ir_write;
    logic       pc_write;
    logic       acc_write;
    logic       pc_inc;
    logic       acc_src;
    logic       acc_clr;
    logic [3:0] alu_op;
    logic       mem_we;
  } ctl_t;
  state_t     state, nxt;
  ctl_t       ctl, ctl_nxt;
  logic [3:0] op, opc;
  logic       skip;
  logic       unused;
  assign unused = ^{bus.acc, bus.ir};
  // The instruction presented during F2 is decoded into the DEC strobes and kept for execute.
  assign opc = state == F2 ? bus.ir[15:12] : op;
`ifdef SKIPCOND_EN
  assign skip = bus.ir[11:10] == 2'b00 ? bus.acc[15] :
                bus.ir[11:10] == 2'b01 ? bus.acc == 16'h0000 :
                bus.ir[11:10] == 2'b10 ? !bus.acc[15] && bus.acc != 16'h0000 : 1'b0;
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? F0 : IDLE;
      F0:      nxt = F1;
      F1:      nxt = F2;
      F2:      nxt = DEC;
      DEC:     nxt = opc inside {4'h1, 4'h2, 4'h3, 4'h4} ? EX0 : opc == 4'h7 ? HALT : F0;
      EX0:     nxt = EX1;
      EX1:     nxt = opc == 4'h2 ? F0 : EX2;
      EX2:     nxt = F0;
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end
  // Strobes are computed for the state being entered so they leave the flops glitch-free.
  always_comb begin
    ctl_nxt = '0;
    case (nxt)
      F0: begin
        ctl_nxt.bus_sel   = 3'd1;
        ctl_nxt.mar_write = 1'b1;
      end
      F2: begin
        ctl_nxt.bus_sel  = 3'd3;
        ctl_nxt.ir_write = 1'b1;
        ctl_nxt.pc_inc   = 1'b1;
      end
      DEC: begin
        ctl_nxt.bus_sel   = opc inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h9} ? 3'd2 : 3'd0;
        ctl_nxt.mar_write = opc inside {4'h1, 4'h2, 4'h3, 4'h4};
        ctl_nxt.pc_write  = opc == 4'h9;
        ctl_nxt.acc_clr   = opc == 4'hA;
        ctl_nxt.pc_inc    = opc == 4'h8 && skip;
      end
      EX0: begin
        ctl_nxt.bus_sel   = opc == 4'h2 ? 3'd5 : 3'd0;
        ctl_nxt.mbr_write = opc == 4'h2;
      end
      EX1: begin
        ctl_nxt.bus_sel   = opc == 4'h2 ? 3'd0 : 3'd3;
        ctl_nxt.mbr_write = opc != 4'h2;
        ctl_nxt.mem_we    = opc == 4'h2;
      end
      EX2: begin
        ctl_nxt.bus_sel   = opc == 4'h1 ? 3'd4 : 3'd0;
        ctl_nxt.acc_write = 1'b1;
        ctl_nxt.acc_src   = opc != 4'h1;
        ctl_nxt.alu_op    = opc == 4'h4 ? 4'b0001 : 4'b0000;
      end
      default: ctl_nxt = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ctl         <= '0;
      op          <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state  <= nxt;
      ctl    <= ctl_nxt;
      halted <= nxt == HALT;
      if (state == F2) begin
        op          <= bus.ir[15:12];
        instr_count <= instr_count + 16'd1;
      end
    end
  end
  assign {bus.bus_sel, bus.mar_write, bus.mbr_write, bus.ir_write, bus.pc_write, bus.acc_write,
          bus.pc_inc, bus.acc_src, bus.acc_clr, bus.alu_op, bus.mem_we} = ctl;
endmodule
